// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a framed big-endian byte stream into 32-bit words for the IMEM write port and holds the CPU in reset until the checksum verifies.
// Latency: the write pulse comes 1 cycle after the 4th byte of a word; done/error come 1 cycle after the CSUM byte.
// Backpressure: in_ready is decoded from state only (high while loading, low in DONE/ERR). Define LOADER_TIMEOUT_EN to enable the inter-byte timeout.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   loaded_words
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;       // first three bytes of the word in flight
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              xfer;
    logic [15:0]       n_len;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0]     tmo_q, tmo_d;
`else
    logic [31:0]       unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    assign in_ready     = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer         = in_valid && in_ready;
    assign n_len        = {len_hi_q, in_data};

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign loaded_words = word_idx_q;

    // Next-state logic: frame parsing, word assembly, checksum and write pulse generation
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        xor_d      = xor_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        case (state_q)
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = n_len;
                    if (32'(n_len) > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (n_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    xor_d = xor_q ^ in_data;
                    if (byte_cnt_q == 2'd3) begin
                        // Word complete: register the write so it pulses next cycle
                        we_d       = 1'b1;
                        addr_d     = 32'(word_idx_q) << 2;
                        wdata_d    = {word_q, in_data};
                        word_idx_d = word_idx_q + IDX_ONE;
                        byte_cnt_d = 2'd0;
                        word_d     = 24'd0;
                        if ((32'(word_idx_q) + 32'd1) == 32'(len_q)) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        word_d     = {word_q[15:0], in_data};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d    = S_LEN_HI;
                    len_hi_d   = 8'd0;
                    len_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_d     = 24'd0;
                    word_idx_d = '0;
                    xor_d      = 8'd0;
                end
            end
            default: state_d = S_LEN_HI;
        endcase

`ifdef LOADER_TIMEOUT_EN
        // Only mid-frame states time out; any transfer restarts the count
        if (xfer || !((state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CSUM))) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_d   = '0;
            state_d = S_ERR;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LEN_HI;
            len_hi_q   <= 8'd0;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'd0;
            word_idx_q <= '0;
            xor_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
`ifdef LOADER_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            xor_q      <= xor_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, bad-checksum, empty, oversize, mid-frame reset, stalled and timeout frames.
// Latency: checks the 1-cycle write pulse and next-cycle done/error.
// Backpressure: in_valid gaps are inserted to confirm the loader only stalls.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              restart;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   loaded_words;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] wq[$];   // observed writes {addr, data}
    logic [7:0]  fr[$];   // frame bytes to send

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .restart      (restart),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .loaded_words (loaded_words)
    );

    always #5 clk = ~clk;

    // Record every write pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer plus gap cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        foreach (fr[i]) send_byte(fr[i], gap);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic check_writes2(input string tag);
        chk({tag, "_nwr"}, 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk({tag, "_a0"}, wq[0][63:32], 32'h0000_0000);
            chk({tag, "_d0"}, wq[0][31:0],  32'h3C08_1234);
            chk({tag, "_a1"}, wq[1][63:32], 32'h0000_0004);
            chk({tag, "_d1"}, wq[1][31:0],  32'h8D09_0004);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we",    32'(imem_we), 32'd0);
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_lw",    32'(loaded_words), 32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(error), 32'd0);

        // Normal frame
        wq.delete();
        fr = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h12, 8'h34, 8'h8D, 8'h09, 8'h00, 8'h04, 8'h92};
        send_frame(0);
        check_writes2("norm");
        chk("norm_done",  32'(done), 32'd1);
        chk("norm_hold",  32'(cpu_hold), 32'd0);
        chk("norm_lw",    32'(loaded_words), 32'd2);
        chk("norm_err",   32'(error), 32'd0);
        chk("norm_ready", 32'(in_ready), 32'd0);

        // Restart from DONE
        do_restart();
        chk("rs1_ready", 32'(in_ready), 32'd1);
        chk("rs1_done",  32'(done), 32'd0);
        chk("rs1_hold",  32'(cpu_hold), 32'd1);
        chk("rs1_lw",    32'(loaded_words), 32'd0);

        // Bad checksum
        wq.delete();
        fr = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h12, 8'h34, 8'h8D, 8'h09, 8'h00, 8'h04, 8'h93};
        send_frame(0);
        check_writes2("bad");
        chk("bad_err",   32'(error), 32'd1);
        chk("bad_hold",  32'(cpu_hold), 32'd1);
        chk("bad_ready", 32'(in_ready), 32'd0);
        chk("bad_done",  32'(done), 32'd0);
        do_restart();
        chk("rs2_ready", 32'(in_ready), 32'd1);
        chk("rs2_err",   32'(error), 32'd0);

        // Empty frame
        wq.delete();
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        chk("empty_nwr",  32'(wq.size()), 32'd0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_hold", 32'(cpu_hold), 32'd0);
        chk("empty_lw",   32'(loaded_words), 32'd0);
        do_restart();

        // Oversize frame: 257 words with a 256-word RAM
        wq.delete();
        fr = '{8'h01, 8'h01};
        send_frame(0);
        chk("over_err",   32'(error), 32'd1);
        chk("over_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("over_nwr",   32'(wq.size()), 32'd0);
        do_restart();

        // Reset mid-frame
        wq.delete();
        fr = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_frame(0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_nwr",   32'(wq.size()), 32'd0);
        chk("mrst_addr",  imem_addr, 32'd0);
        chk("mrst_wdata", imem_wdata, 32'd0);
        chk("mrst_hold",  32'(cpu_hold), 32'd1);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        chk("mrst_lw",    32'(loaded_words), 32'd0);

        // Following frame, with write-latency checks
        fr = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        send_frame(0);
        chk("lat_pre_we", 32'(imem_we), 32'd0);
        send_byte(8'h44, 0);
        chk("lat_we",    32'(imem_we), 32'd1);
        chk("lat_addr",  imem_addr, 32'd0);
        chk("lat_wdata", imem_wdata, 32'h1122_3344);
        chk("lat_lw",    32'(loaded_words), 32'd1);
        send_byte(8'h44, 0);
        chk("lat_we_off", 32'(imem_we), 32'd0);
        chk("lat_hold",   imem_wdata, 32'h1122_3344);
        chk("lat_done",   32'(done), 32'd1);
        chk("lat_nwr",    32'(wq.size()), 32'd1);
        do_restart();

        // Stalled normal frame
        wq.delete();
        fr = '{8'h00, 8'h02, 8'h3C, 8'h08, 8'h12, 8'h34, 8'h8D, 8'h09, 8'h00, 8'h04, 8'h92};
        send_frame(5);
        check_writes2("stall");
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_hold", 32'(cpu_hold), 32'd0);
        chk("stall_lw",   32'(loaded_words), 32'd2);
        do_restart();

        // Abandoned frame: timeout if enabled, otherwise indefinite wait
        fr = '{8'h00, 8'h01, 8'hAA};
        send_frame(0);
`ifdef LOADER_TIMEOUT_EN
        repeat (19) @(negedge clk);
        chk("tmo_err_19", 32'(error), 32'd0);
        @(negedge clk);
        chk("tmo_err_20",  32'(error), 32'd1);
        chk("tmo_hold",    32'(cpu_hold), 32'd1);
        chk("tmo_ready",   32'(in_ready), 32'd0);
`else
        repeat (40) @(negedge clk);
        chk("wait_err",   32'(error), 32'd0);
        chk("wait_ready", 32'(in_ready), 32'd1);
        chk("wait_hold",  32'(cpu_hold), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the fetch stage reads by PC.
- Accepts a framed byte stream, for example from a UART receiver, and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction RAM write port at word-aligned byte addresses.
- Holds the CPU in reset until a frame is loaded and its checksum verifies.

Parameters:
- ADDR_W, 8, instruction RAM word-address bits; capacity DEPTH = 2^ADDR_W words.
- TIMEOUT, 1000, inter-byte timeout in clk cycles. Used only with LOADER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte; a transfer occurs when in_valid && in_ready at a rising clk edge
- restart  input  1  one-cycle pulse; re-arms the loader from DONE or ERR
- imem_we  output  1  instruction RAM write enable, one-cycle pulse per word
- imem_addr  output  32  byte address, word-aligned, = word_idx<<2
- imem_wdata  output  32  assembled instruction word
- cpu_hold  output  1  high keeps the CPU in reset
- done  output  1  frame loaded and verified
- error  output  1  frame rejected
- loaded_words  output  ADDR_W+1  number of words written in the current frame

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes (each word MSB first), then one CSUM byte. CSUM is the XOR of all data bytes; the length bytes are excluded.
- States: LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- Reset values:
  - State = LEN_HI.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0, loaded_words = 0.
  - cpu_hold = 1, done = 0, error = 0.
  - Byte counter, word index and running XOR all cleared.
- in_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERR. It is decoded from state only, with no combinational path from in_valid.
- LEN_HI: on transfer, latch the high byte and go to LEN_LO.
- LEN_LO: on transfer, form N, then:
  - N > DEPTH: go to ERR; no writes occur.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: each transfer shifts the byte into the word register and XORs it into the checksum.
  - On the 4th byte of a word, the next cycle drives imem_we = 1 for exactly one cycle, with imem_addr = word_idx<<2 and imem_wdata = the assembled word. Write latency is 1 cycle after the 4th byte is accepted.
  - word_idx and loaded_words increment with the write.
  - After the write of word N-1, go to CSUM.
  - The byte accepted in the cycle the write pulse is driven is processed normally; no bytes are dropped.
- CSUM: on transfer, compare the byte with the running XOR.
  - Equal: go to DONE. The next cycle has done = 1 and cpu_hold = 0.
  - Not equal: go to ERR with error = 1; cpu_hold stays 1.
- DONE / ERR: outputs hold. A restart pulse goes to LEN_HI on the next cycle; cpu_hold = 1, done = error = 0, and the counters and XOR clear. restart is ignored in all other states.
- in_valid gaps at any point only stall the loader; no state advance and no write occur while no transfer happens.
- Reset mid-frame: immediate return to reset values. Partially assembled words are discarded; RAM contents already written are not erased.
- imem_addr and imem_wdata hold their last values between write pulses.
- Width rules: word_idx is ADDR_W+1 bits and never exceeds DEPTH; imem_addr upper bits are zero-extended.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: a counter clears on every transfer and counts in LEN_LO, DATA and CSUM. When it reaches TIMEOUT cycles without a transfer, the loader goes to ERR (error = 1, cpu_hold = 1). LEN_HI, DONE and ERR never time out.
- Undefined: no counter is present; the loader waits indefinitely.

Test Plan:
- Normal frame: bytes 00 02 3C 08 12 34 8D 09 00 04 92 -> imem_we pulses with addr 0x0 data 0x3C081234, then addr 0x4 data 0x8D090004. Then done = 1, cpu_hold = 0, loaded_words = 2.
- Bad checksum: the same frame with final byte 93 -> two writes occur, then error = 1, cpu_hold = 1, in_ready = 0. A restart pulse then gives in_ready = 1 and error = 0.
- Empty frame: 00 00 00 -> no imem_we; done = 1, cpu_hold = 0, loaded_words = 0.
- Oversize frame: with ADDR_W = 8, bytes 01 01 -> ERR immediately after LEN_LO, no imem_we, in_ready = 0.
- Reset mid-frame: reset after bytes 00 01 AA BB -> no write and all outputs at reset values. A following frame 00 01 11 22 33 44 44 writes 0x11223344 at 0x0 and sets done = 1.
- Stalls and timeout:
  - Normal frame with in_valid deasserted for 5 cycles between every byte -> identical writes and results.
  - With LOADER_TIMEOUT_EN and TIMEOUT = 20, stopping after 00 01 AA -> error = 1 exactly 20 cycles after the last transfer.
